// File: rtl/operand_loader_1024_if.sv
// rtl/operand_loader_1024_if.sv - word stream, operand and multiplier handshake bundle for operand_loader_1024
interface operand_loader_1024_if #(
    parameter int OP_W   = 1024,
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic              mul_start;
    logic              mul_done;
    logic              busy;
    logic [15:0]       job_cnt;
    logic              chk_err;

    modport slave (
        input  in_valid, in_data, mul_done,
        output in_ready, op_a, op_b, mul_start, busy, job_cnt, chk_err
    );

    modport master (
        output in_valid, in_data, mul_done,
        input  in_ready, op_a, op_b, mul_start, busy, job_cnt, chk_err
    );
endinterface

// File: rtl/operand_loader_1024.sv
// rtl/operand_loader_1024.sv - collects operands A and B from a word stream and launches the 1024-bit multiplier (optional LOADER_CHECKSUM_EN)
module operand_loader_1024 #(
    parameter int OP_W   = 1024,
    parameter int WORD_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    operand_loader_1024_if.slave   bus
);
    localparam int NWORDS = OP_W / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [2:0] {
        LOAD_A    = 3'd0,
        LOAD_B    = 3'd1,
        LOAD_CK   = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic [15:0]       job_cnt_q, job_cnt_d;
    logic [OP_W-1:0]   op_a_q, op_b_q;
    logic              armed_q;
    logic              in_load;
    logic              accept;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] acc_q;
    logic              chk_err_q, chk_err_d;
    logic              ck_ok;

    assign ck_ok = (bus.in_data == acc_q);
`endif

    // in_ready stays low through reset and until the first edge after it is released.
    assign in_load      = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_CK);
    assign bus.in_ready = armed_q & in_load;
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.mul_start = (state_q == ISSUE);
    assign bus.busy      = busy_q;
    assign bus.job_cnt   = job_cnt_q;

    // Control state register, word index, busy flag and job counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= LOAD_A;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            job_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            job_cnt_q <= job_cnt_d;
            armed_q   <= 1'b1;
        end
    end

    // Next-state logic: walk the word index through A then B, then launch and wait.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        job_cnt_d = job_cnt_q;
`ifdef LOADER_CHECKSUM_EN
        chk_err_d = 1'b0;
`endif
        case (state_q)
            LOAD_A: begin
                if (accept) begin
                    busy_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                        state_d = LOAD_CK;
`else
                        state_d = ISSUE;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            LOAD_CK: begin
                if (accept) begin
                    if (ck_ok) begin
                        state_d = ISSUE;
                    end else begin
                        chk_err_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = LOAD_A;
                    end
                end
            end
`endif
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.mul_done) begin
                    busy_d    = 1'b0;
                    job_cnt_d = (job_cnt_q == 16'hFFFF) ? job_cnt_q : job_cnt_q + 16'd1;
                    state_d   = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
        endcase
    end

    // Drop each accepted operand word into its slot; operands never change otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (accept) begin
            if (state_q == LOAD_A) begin
                op_a_q[idx_q*WORD_W +: WORD_W] <= bus.in_data;
            end else if (state_q == LOAD_B) begin
                op_b_q[idx_q*WORD_W +: WORD_W] <= bus.in_data;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of the operand words of the current job; restarts on word 0 of A.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
        end else if (accept && (state_q != LOAD_CK)) begin
            acc_q <= ((state_q == LOAD_A) && (idx_q == '0)) ? bus.in_data : (acc_q ^ bus.in_data);
        end
    end

    // Registered one-cycle checksum error pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign bus.chk_err = chk_err_q;
`else
    assign bus.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_operand_loader_1024.sv
// tb/tb_operand_loader_1024.sv - randomized self-checking bench for operand_loader_1024
module tb_operand_loader_1024;
    localparam int OP_W   = 1024;
    localparam int WORD_W = 32;
    localparam int NWORDS = OP_W / WORD_W;

    typedef logic [WORD_W-1:0] word_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    operand_loader_1024_if #(.OP_W(OP_W), .WORD_W(WORD_W)) bus ();

    operand_loader_1024 #(.OP_W(OP_W), .WORD_W(WORD_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad = 0;
    int exp_jobs = 0;
    logic [OP_W-1:0] exp_a;
    logic [OP_W-1:0] exp_b;

    function automatic logic [OP_W-1:0] pack_op(input word_t w[$]);
        logic [OP_W-1:0] r = '0;
        for (int k = 0; k < NWORDS; k++) r = r | (OP_W'(w[k]) << (k * WORD_W));
        return r;
    endfunction

    // Builds the stream for a job and records the expected operands.
    task automatic build_job(input word_t a[$], input word_t b[$], output word_t s[$]);
        word_t x = '0;
        s = {};
        foreach (a[k]) begin s.push_back(a[k]); x = x ^ a[k]; end
        foreach (b[k]) begin s.push_back(b[k]); x = x ^ b[k]; end
`ifdef LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
        exp_a = pack_op(a);
        exp_b = pack_op(b);
    endtask

    task automatic rand_words(output word_t w[$]);
        w = {};
        for (int k = 0; k < NWORDS; k++) w.push_back(word_t'($urandom));
    endtask

    // mode 0: valid held high; 1: valid toggles 1,0,1,0; 2: random valid.
    task automatic drive(input word_t s[$], input int mode, output int starts, output bit timeout);
        int i = 0;
        int cyc = 0;
        logic v;
        starts = 0;
        timeout = 1'b0;
        while (i < s.size()) begin
            @(negedge clk);
            if (bus.mul_start === 1'b1) starts++;
            if (cyc > 3000) begin timeout = 1'b1; break; end
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            bus.in_valid = v;
            bus.in_data  = v ? s[i] : word_t'($urandom);
            if (v && (bus.in_ready === 1'b1)) i++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Called at the ISSUE cycle: checks the launch, waits, then pulses mul_done.
    task automatic launch_and_done(input string tag, input int starts, input bit timeout, input int delay);
        total++; if (timeout) begin bad++; $display("FAIL %s_timeout: stream not consumed", tag); end
        total++; if (starts !== 0) begin bad++; $display("FAIL %s_early_start: got %0d want 0", tag, starts); end
        total++; if (bus.mul_start !== 1'b1) begin bad++; $display("FAIL %s_start: got %b want 1", tag, bus.mul_start); end
        total++; if (bus.op_a !== exp_a) begin bad++; $display("FAIL %s_op_a: got %h want %h", tag, bus.op_a[63:0], exp_a[63:0]); end
        total++; if (bus.op_b !== exp_b) begin bad++; $display("FAIL %s_op_b: got %h want %h", tag, bus.op_b[63:0], exp_b[63:0]); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b want 1", tag, bus.busy); end
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = word_t'($urandom);
            total++; if (bus.mul_start !== 1'b0) begin bad++; $display("FAIL %s_start_width: got %b want 0", tag, bus.mul_start); end
            total++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL %s_wait: ready=%b busy=%b want 0/1", tag, bus.in_ready, bus.busy); end
        end
        total++; if (bus.op_a !== exp_a || bus.op_b !== exp_b) begin bad++; $display("FAIL %s_hold: operands changed in wait", tag); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mul_done = 1'b1;
        @(negedge clk);
        bus.mul_done = 1'b0;
        exp_jobs++;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_busy_clear: got %b want 0", tag, bus.busy); end
        total++; if (bus.job_cnt !== 16'(exp_jobs)) begin bad++; $display("FAIL %s_job_cnt: got %0d want %0d", tag, bus.job_cnt, exp_jobs); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL %s_rearm: got %b want 1", tag, bus.in_ready); end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.mul_done = 1'b0;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0 || bus.mul_start !== 1'b0 || bus.busy !== 1'b0 || bus.chk_err !== 1'b0)
            begin bad++; $display("FAIL reset_flags: ready=%b start=%b busy=%b err=%b want 0", bus.in_ready, bus.mul_start, bus.busy, bus.chk_err); end
        total++; if (bus.op_a !== '0 || bus.op_b !== '0 || bus.job_cnt !== 16'd0)
            begin bad++; $display("FAIL reset_data: job_cnt=%0d want 0 with zero operands", bus.job_cnt); end
        resetn = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_early: got %b want 0", bus.in_ready); end
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic(input int mode, input string tag);
        word_t a[$], b[$], s[$];
        int st;
        bit to;
        a = {}; b = {};
        for (int k = 0; k < NWORDS; k++) begin a.push_back(k == 0 ? 32'd1 : 32'd0); b.push_back(k == 0 ? 32'd3 : 32'd0); end
        build_job(a, b, s);
        drive(s, mode, st, to);
        launch_and_done(tag, st, to, 4);
    endtask

    task automatic test_back_to_back();
        word_t a[$], b[$], s[$];
        int st;
        bit to;
        rand_words(a); rand_words(b);
        build_job(a, b, s);
        drive(s, 0, st, to);
        launch_and_done("b2b", st, to, 1);
    endtask

    task automatic test_done_ignored();
        word_t a[$], b[$], s[$];
        int st;
        bit to;
        bus.mul_done = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.job_cnt !== 16'(exp_jobs) || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            begin bad++; $display("FAIL done_idle: job_cnt=%0d busy=%b ready=%b want %0d/0/1", bus.job_cnt, bus.busy, bus.in_ready, exp_jobs); end
        rand_words(a); rand_words(b);
        build_job(a, b, s);
        drive(s, 2, st, to);
        total++; if (to || st !== 0 || bus.mul_start !== 1'b1) begin bad++; $display("FAIL done_issue: start=%b early=%0d", bus.mul_start, st); end
        total++; if (bus.job_cnt !== 16'(exp_jobs) || bus.busy !== 1'b1) begin bad++; $display("FAIL done_in_issue: job_cnt=%0d busy=%b want %0d/1", bus.job_cnt, bus.busy, exp_jobs); end
        @(negedge clk);
        total++; if (bus.job_cnt !== 16'(exp_jobs) || bus.busy !== 1'b1) begin bad++; $display("FAIL done_wait_entry: job_cnt=%0d busy=%b want %0d/1", bus.job_cnt, bus.busy, exp_jobs); end
        @(negedge clk);
        bus.mul_done = 1'b0;
        exp_jobs++;
        total++; if (bus.job_cnt !== 16'(exp_jobs) || bus.busy !== 1'b0) begin bad++; $display("FAIL done_wait: job_cnt=%0d busy=%b want %0d/0", bus.job_cnt, bus.busy, exp_jobs); end
        total++; if (bus.op_a !== exp_a || bus.op_b !== exp_b) begin bad++; $display("FAIL done_ops: operands differ from stream"); end
    endtask

    task automatic test_random();
        word_t a[$], b[$], s[$];
        int st;
        bit to;
        for (int j = 0; j < 3; j++) begin
            rand_words(a); rand_words(b);
            build_job(a, b, s);
            drive(s, 2, st, to);
            launch_and_done($sformatf("rand%0d", j), st, to, $urandom_range(0, 6));
        end
    endtask

    task automatic test_reset_mid();
        word_t a[$], b[$], s[$], part[$];
        int st;
        bit to;
        rand_words(a); rand_words(b);
        build_job(a, b, s);
        part = s[0:39];
        drive(part, 0, st, to);
        resetn = 1'b0;
        #1;
        exp_jobs = 0;
        total++; if (bus.op_a !== '0 || bus.op_b !== '0) begin bad++; $display("FAIL midrst_ops: operands not cleared"); end
        total++; if (bus.busy !== 1'b0 || bus.job_cnt !== 16'd0 || bus.in_ready !== 1'b0)
            begin bad++; $display("FAIL midrst_flags: busy=%b job_cnt=%0d ready=%b want 0/0/0", bus.busy, bus.job_cnt, bus.in_ready); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        rand_words(a); rand_words(b);
        build_job(a, b, s);
        drive(s, 0, st, to);
        launch_and_done("midrst_restart", st, to, 2);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        word_t a[$], b[$], s[$];
        int st;
        bit to;
        a = {}; b = {};
        for (int k = 0; k < NWORDS; k++) begin a.push_back(32'hFFFF_FFFF); b.push_back(32'h0); end
        build_job(a, b, s);
        total++; if (s[2*NWORDS] !== 32'h0) begin bad++; $display("FAIL ck_model: got %h want 0", s[2*NWORDS]); end
        drive(s, 0, st, to);
        total++; if (bus.chk_err !== 1'b0) begin bad++; $display("FAIL ck_match_err: got %b want 0", bus.chk_err); end
        launch_and_done("ck_match", st, to, 2);
        s[2*NWORDS] = 32'h1;
        drive(s, 0, st, to);
        total++; if (to || bus.chk_err !== 1'b1 || bus.mul_start !== 1'b0)
            begin bad++; $display("FAIL ck_bad: err=%b start=%b want 1/0", bus.chk_err, bus.mul_start); end
        total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.op_a !== exp_a)
            begin bad++; $display("FAIL ck_bad_state: busy=%b ready=%b want 0/1 with stale op_a", bus.busy, bus.in_ready); end
        @(negedge clk);
        total++; if (bus.chk_err !== 1'b0 || bus.mul_start !== 1'b0 || bus.job_cnt !== 16'(exp_jobs))
            begin bad++; $display("FAIL ck_bad_pulse: err=%b start=%b job_cnt=%0d", bus.chk_err, bus.mul_start, bus.job_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic(0, "basic");
        test_back_to_back();
        test_basic(1, "gaps");
        test_done_ignored();
        test_random();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
